pdm_deserializer_fifo: RTL and testbench
========================================

# pdm_deserializer_fifo

Parametrised PDM microphone front end that generates the PDM clock from the system clock and deserialises one (mono) or two (stereo, shared data line) bit streams into WIDTH-bit words. Completed words are tagged with their channel and buffered in a DEPTH-entry FIFO with a valid/ready output handshake. It sits between the board PDM microphone pins and the downstream decimation/storage logic in the audio recorder, as the successor of the fixed 16-bit, single-channel deserializer.

## Interface
- CLK_DIV, 50: clock_i cycles per PDM clock half-period; ≥1 (50 gives 1 MHz from 100 MHz).
- WIDTH, 16: bits per output word; 2..32.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- clock_i  in  1  system clock; all logic on rising edge.
- resetn_i  in  1  synchronous active-low reset.
- enable_i  in  1  run; low stops PDM clock and discards partial words.
- pdm_clk_o  out  1  PDM clock to microphone(s).
- pdm_data_i  in  1  PDM data line.
- pdm_lrsel_o  out  1  L/R select to the primary microphone; constant 0.
- data_o  out  WIDTH  FIFO head word; 0 when FIFO empty.
- channel_o  out  1  FIFO head channel: 0 = left, 1 = right.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  consumer accepts head when valid_o & ready_i.
- level_o  out  clog2(DEPTH)+1  FIFO occupancy.
- overflow_o  out  1  sticky: a completed word was dropped.

## Operation
- Divider: counter 0..CLK_DIV-1 runs while enable_i=1; at terminal count it wraps and pdm_clk_o toggles. Enable low: counter=0, pdm_clk_o=0.
- Rise event: cycle in which pdm_clk_o is driven 0→1. Fall event: cycle driven 1→0. pdm_data_i is sampled in that event cycle (value present just before the edge).
- Left channel samples on rise events; right channel (stereo only) on fall events.
- Each channel has its own WIDTH-bit shift register and bit counter. Each sample shifts right, new bit enters MSB; after WIDTH samples the first-received bit sits in bit 0. On the WIDTHth sample the completed word (including that sample) is pushed as {channel, word}; counter restarts at 0. No sample is lost at word boundaries.
- Left and right pushes fall in different cycles (separated by CLK_DIV), never simultaneous.
- FIFO: first-word fall-through; pop when valid_o & ready_i.
- Push while full: word dropped, overflow_o set, contents unchanged. Push and pop in the same cycle while full: both happen, level unchanged, no overflow.
- Pop while empty: ignored.
- enable_i low: shift registers and bit counters cleared, overflow_o cleared, FIFO contents retained and still drainable.
- resetn_i low at a clock edge: everything cleared, including FIFO, regardless of enable_i.

## Timing
- Reset values: pdm_clk_o 0, pdm_lrsel_o 0, data_o 0, channel_o 0, valid_o 0, level_o 0, overflow_o 0.
- After enable_i rises: first rise event CLK_DIV cycles later; PDM period 2·CLK_DIV cycles.
- Push latency: valid_o, level_o and data_o/channel_o reflect a push in the cycle after the push cycle.
- Pop: level_o decrements and the next head appears in the cycle after the handshake.
- overflow_o asserts in the cycle after the dropping push.
- enable_i falling: pdm_clk_o is 0 from the next cycle; a word completing in that cycle is not pushed.

## Configuration
- PDM_DESER_STEREO_EN defined: right channel active (fall-event sampling, second shift register), words alternate left/right.
- Undefined: right channel logic absent; only left words pushed, channel_o constant 0.
- pdm_lrsel_o is 0 in both builds.

## Test plan
- Reset/clock: CLK_DIV=50, hold resetn_i=0 then enable -> all outputs 0 in reset; first pdm_clk_o rise 50 cycles after enable, period 100 cycles.
- Mono word: left bits 1 then fifteen 0 -> one entry 16'h0001, channel_o=0, valid_o one cycle after 16th rise event.
- Stereo (PDM_DESER_STEREO_EN): data 1 at rise events, 0 at fall events for 32 PDM periods -> FIFO order FFFF/ch0, 0000/ch1, FFFF/ch0, 0000/ch1.
- Overflow: DEPTH=4, ready_i=0, five mono words -> level_o=4, overflow_o=1, draining returns first four words in order; a push coincident with a pop when full does not set overflow.
- Enable abort: drop enable_i after 7 bits -> pdm_clk_o 0 next cycle, no push, overflow_o cleared; re-enable and feed 16 bits of 16'hA5A5 -> exactly 16'hA5A5 pushed.
- Reset mid-operation: resetn_i=0 with 3 FIFO entries and partial word -> level_o=0, valid_o=0, data_o=0 next cycle.

Source files
------------

// File: rtl/pdm_deserializer_fifo.sv
// pdm_deserializer_fifo: PDM clock generator, left/right bit-stream deserialiser
// and first-word-fall-through output FIFO with valid/ready handshake.
// Optional build macro: PDM_DESER_STEREO_EN enables the right channel, which
// samples on PDM clock fall events into its own shift register. Without it
// only the left channel exists and channel_o is tied to 0.
module pdm_deserializer_fifo #(
  parameter int CLK_DIV = 50,
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4
) (
  input  logic                     clock_i,
  input  logic                     resetn_i,
  input  logic                     enable_i,
  output logic                     pdm_clk_o,
  input  logic                     pdm_data_i,
  output logic                     pdm_lrsel_o,
  output logic [WIDTH-1:0]         data_o,
  output logic                     channel_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam int PTR_W = $clog2(DEPTH);
`ifdef PDM_DESER_STEREO_EN
  localparam int NCH = 2;
`else
  localparam int NCH = 1;
`endif

  // ---------------------------------------------------------------------------
  // PDM clock divider
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_reg;
  logic             pdm_clk_reg;
  logic             div_tick;
  logic             rise_evt;

  // Terminal count only counts while running, so a disabled divider never toggles.
  assign div_tick = enable_i && (div_cnt_reg == DIV_W'(CLK_DIV - 1));
  assign rise_evt = div_tick && !pdm_clk_reg;

  // Divider counter and PDM clock toggle; both park at 0 while disabled.
  always_ff @(posedge clock_i) begin
    if (!resetn_i || !enable_i) begin
      div_cnt_reg <= '0;
      pdm_clk_reg <= 1'b0;
    end else if (div_tick) begin
      div_cnt_reg <= '0;
      pdm_clk_reg <= !pdm_clk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  assign pdm_clk_o   = pdm_clk_reg;
  assign pdm_lrsel_o = 1'b0;

  // ---------------------------------------------------------------------------
  // Per-channel deserialisers (channel 0 = left on rise, 1 = right on fall)
  // ---------------------------------------------------------------------------
  logic [NCH-1:0]   chan_evt;
  logic [NCH-1:0]   chan_done;
  logic [WIDTH-1:0] chan_word [NCH];

  assign chan_evt[0] = rise_evt;
`ifdef PDM_DESER_STEREO_EN
  logic fall_evt;
  assign fall_evt    = div_tick && pdm_clk_reg;
  assign chan_evt[1] = fall_evt;
`endif

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    // Only the upper WIDTH-1 bits are kept: the bit that falls out of the
    // bottom on the completing sample is already part of the pushed word.
    logic [WIDTH-2:0] sr_reg;
    logic [BIT_W-1:0] cnt_reg;

    assign chan_word[gi] = {pdm_data_i, sr_reg};
    assign chan_done[gi] = chan_evt[gi] && (cnt_reg == BIT_W'(WIDTH - 1));

    // Shift in one bit per channel event; the counter wraps on word completion.
    always_ff @(posedge clock_i) begin
      if (!resetn_i || !enable_i) begin
        sr_reg  <= '0;
        cnt_reg <= '0;
      end else if (chan_evt[gi]) begin
        sr_reg  <= chan_word[gi][WIDTH-1:1];
        cnt_reg <= chan_done[gi] ? '0 : cnt_reg + BIT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Push selection: left and right never complete in the same cycle.
  // ---------------------------------------------------------------------------
  logic             push;
  logic [WIDTH-1:0] push_word;

  assign push = |chan_done;
`ifdef PDM_DESER_STEREO_EN
  logic push_ch;
  assign push_word = chan_done[1] ? chan_word[1] : chan_word[0];
  assign push_ch   = chan_done[1];
`else
  assign push_word = chan_word[0];
`endif

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_data [DEPTH];
`ifdef PDM_DESER_STEREO_EN
  logic             mem_ch   [DEPTH];
`endif
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   level_reg;
  logic             overflow_reg;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             wr_en;

  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == (PTR_W + 1)'(DEPTH));
  assign pop        = !fifo_empty && ready_i;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign wr_en      = push && (!fifo_full || pop);

  // Storage array: written at the tail, no reset needed since level gates reads.
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      mem_data[wr_ptr_reg] <= push_word;
`ifdef PDM_DESER_STEREO_EN
      mem_ch[wr_ptr_reg]   <= push_ch;
`endif
    end
  end

  // Pointers and occupancy; FIFO contents survive enable_i low.
  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   level_reg <= level_reg + (PTR_W + 1)'(1);
        2'b01:   level_reg <= level_reg - (PTR_W + 1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Sticky drop flag, cleared by reset or by stopping the front end.
  always_ff @(posedge clock_i) begin
    if (!resetn_i || !enable_i) begin
      overflow_reg <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow_reg <= 1'b1;
    end
  end

  assign valid_o    = !fifo_empty;
  assign level_o    = level_reg;
  assign overflow_o = overflow_reg;
  assign data_o     = fifo_empty ? '0 : mem_data[rd_ptr_reg];
`ifdef PDM_DESER_STEREO_EN
  assign channel_o  = fifo_empty ? 1'b0 : mem_ch[rd_ptr_reg];
`else
  assign channel_o  = 1'b0;
`endif

endmodule

// File: tb/tb_pdm_deserializer_fifo.sv
// Directed testbench for pdm_deserializer_fifo (CLK_DIV=50, WIDTH=16, DEPTH=4).
// The default build exercises the mono path; with PDM_DESER_STEREO_EN defined
// the stereo ordering test runs instead.
module tb_pdm_deserializer_fifo;
  localparam int CLK_DIV = 50;
  localparam int WIDTH   = 16;
  localparam int DEPTH   = 4;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             enable = 1'b0;
  logic             pdm_data = 1'b0;
  logic             ready = 1'b0;
  logic             pdm_clk;
  logic             pdm_lrsel;
  logic [WIDTH-1:0] data;
  logic             channel;
  logic             valid;
  logic [2:0]       level;
  logic             overflow;

  int n_checks = 0;
  int n_errors = 0;
  int c;

  pdm_deserializer_fifo #(.CLK_DIV(CLK_DIV), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock_i     (clk),
    .resetn_i    (resetn),
    .enable_i    (enable),
    .pdm_clk_o   (pdm_clk),
    .pdm_data_i  (pdm_data),
    .pdm_lrsel_o (pdm_lrsel),
    .data_o      (data),
    .channel_o   (channel),
    .valid_o     (valid),
    .ready_i     (ready),
    .level_o     (level),
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait for pdm_clk to make the requested transition; returns cycles waited.
  task automatic wait_pdm(input logic want, output int cycles);
    logic prev;
    logic cur;
    bit   hit;
    hit    = 1'b0;
    cycles = 0;
    prev   = pdm_clk;
    for (int i = 0; i < 4 * CLK_DIV; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      cur = pdm_clk;
      if (cur === want && prev === ~want) begin
        hit = 1'b1;
        break;
      end
      prev = cur;
    end
    n_checks++;
    assert (hit) else begin
      n_errors++;
      $error("FAIL pdm_edge_timeout observed=no_edge expected=edge want=%0b", want);
    end
  endtask

  task automatic send_bit(input logic b);
    int cyc;
    pdm_data = b;
    wait_pdm(1'b1, cyc);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 16; i++) send_bit(w[i]);
  endtask

  logic [15:0] ovf_words [5];
  logic [15:0] drain_exp [4];
  logic [15:0] w5;

  initial begin
    ovf_words = '{16'h1234, 16'hBEEF, 16'h0F0F, 16'hCAFE, 16'h5555};
    drain_exp = '{16'hBEEF, 16'h0F0F, 16'hCAFE, 16'h9C3A};
    w5        = 16'h9C3A;

    // Reset held with enable high: everything must stay at 0.
    resetn = 1'b0;
    enable = 1'b1;
    tick_n(3);
    check("rst_pdm_clk", pdm_clk, 0);
    check("rst_lrsel", pdm_lrsel, 0);
    check("rst_data", data, 0);
    check("rst_channel", channel, 0);
    check("rst_valid", valid, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    enable = 1'b0;
    tick_n(1);
    resetn = 1'b1;
    tick_n(2);

`ifdef PDM_DESER_STEREO_EN
    // 1 at every rise, 0 at every fall, 32 PDM periods.
    pdm_data = 1'b1;
    enable   = 1'b1;
    for (int p = 0; p < 32; p++) begin
      wait_pdm(1'b1, c);
      pdm_data = 1'b0;
      wait_pdm(1'b0, c);
      pdm_data = 1'b1;
    end
    check("st_level", level, 4);
    check("st_overflow", overflow, 0);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("st_data", data, (i % 2 == 0) ? 32'hFFFF : 32'h0000);
      check("st_channel", channel, i % 2);
      ready = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b0;
    end
    check("st_empty", valid, 0);
`else
    // Clock timing after enable.
    pdm_data = 1'b0;
    enable   = 1'b1;
    wait_pdm(1'b1, c);
    check("first_rise_cycles", c, CLK_DIV);
    wait_pdm(1'b1, c);
    check("pdm_period", c, 2 * CLK_DIV);
    enable = 1'b0;
    tick_n(1);
    check("disable_clk_low", pdm_clk, 0);

    // Single mono word: 1 then fifteen 0s -> 16'h0001.
    enable = 1'b1;
    send_bit(1'b1);
    for (int i = 0; i < 14; i++) send_bit(1'b0);
    check("valid_before_16th", valid, 0);
    send_bit(1'b0);
    check("mono_valid", valid, 1);
    check("mono_data", data, 16'h0001);
    check("mono_channel", channel, 0);
    check("mono_level", level, 1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    check("pop_level", level, 0);
    check("pop_valid", valid, 0);
    check("pop_data_zero", data, 0);

    // Overflow: five words, no consumer.
    for (int k = 0; k < 5; k++) begin
      send_word(ovf_words[k]);
      if (k == 3) begin
        check("full_level", level, 4);
        check("full_no_overflow", overflow, 0);
      end
    end
    check("ovf_level", level, 4);
    check("ovf_flag", overflow, 1);
    enable = 1'b0;
    tick_n(1);
    check("ovf_cleared_by_disable", overflow, 0);
    check("fifo_retained_level", level, 4);
    check("fifo_retained_head", data, 16'h1234);

    // Push coinciding with pop while full.
    enable = 1'b1;
    for (int i = 0; i < 15; i++) send_bit(w5[i]);
    pdm_data = w5[15];
    wait_pdm(1'b0, c);
    tick_n(CLK_DIV - 1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    check("coincident_rise", pdm_clk, 1);
    check("coincident_level", level, 4);
    check("coincident_no_ovf", overflow, 0);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("drain_data", data, drain_exp[i]);
      ready = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b0;
    end
    check("drain_empty_valid", valid, 0);
    check("drain_empty_level", level, 0);

    // Enable abort after 7 bits, then a clean word.
    enable = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    enable = 1'b0;
    tick_n(1);
    check("abort_clk_low", pdm_clk, 0);
    check("abort_no_push", level, 0);
    check("abort_overflow", overflow, 0);
    enable = 1'b1;
    send_word(16'hA5A5);
    check("a5_level", level, 1);
    check("a5_data", data, 16'hA5A5);
    check("a5_valid", valid, 1);

    // Reset mid-operation with 3 entries and a partial word.
    send_word(16'h0F00);
    send_word(16'h00F0);
    check("pre_reset_level", level, 3);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    resetn = 1'b0;
    tick_n(1);
    check("midrst_level", level, 0);
    check("midrst_valid", valid, 0);
    check("midrst_data", data, 0);
    check("midrst_pdm_clk", pdm_clk, 0);
    resetn = 1'b1;
    enable = 1'b0;
    tick_n(1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
